// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream, writes it
// into RAM word by word, and releases the CPU only after the checksum matches.
//
// Frame: 8'hA5, LEN_HI, LEN_LO, LEN words (high byte first), CHK
//   CHK = XOR of all data bytes (8'h00 when LEN = 0)
//
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
// are both 1. rx_valid may be held high for back-to-back bytes; rx_ready is
// 1 in every state except DONE, so the loader never stalls mid-frame.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   rx_data    incoming byte
//   rx_valid   rx_data valid
//   rx_ready   loader accepts a byte this cycle
//   mem_addr   RAM write address (PROG_START + word index, 16-bit wrap)
//   mem_wdata  RAM write data
//   mem_we     one-cycle RAM write strobe
//   cpu_rst    1 = CPU held in reset; 0 only once DONE is reached
//   load_err   sticky error flag for the current load attempt
//   word_cnt   words written so far in the current load
//   dbg_state  current FSM state encoding, for observation
module prog_loader #(
    parameter logic [15:0] PROG_START = 16'h000F,
    parameter logic [15:0] MAX_WORDS  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        load_err,
    output logic [15:0] word_cnt,
    output logic [2:0]  dbg_state
);

    localparam logic [7:0] MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    state_t      state;
    logic        rdy_q;
    logic        we_q;
    logic [15:0] len_q;
    logic [7:0]  hi_q;
    logic [7:0]  xor_q;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] cnt_next;

    // Gating with rst keeps both strobes low for the whole time reset is
    // held, including the first cycle before the reset edge lands, so a
    // write pending from the last DATA_LO is also suppressed.
    assign rx_ready  = rdy_q & rst;
    assign mem_we    = we_q & rst;
    assign dbg_state = state;

    assign accept   = rx_valid & rx_ready;
    assign len_full = {len_q[15:8], rx_data};
    assign cnt_next = word_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            cpu_rst   <= 1'b1;
            load_err  <= 1'b0;
            word_cnt  <= 16'h0000;
            len_q     <= 16'h0000;
            hi_q      <= 8'h00;
            xor_q     <= 8'h00;
        end else begin
            we_q  <= 1'b0;
            rdy_q <= (state != DONE);
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (rx_data == MAGIC) begin
                            state    <= LEN_HI;
                            word_cnt <= 16'h0000;
                            xor_q    <= 8'h00;
                        end
                    end
                    LEN_HI: begin
                        len_q[15:8] <= rx_data;
                        state       <= LEN_LO;
                    end
                    LEN_LO: begin
                        len_q <= len_full;
                        if (len_full > MAX_WORDS) begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end else if (len_full == 16'h0000) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hi_q  <= rx_data;
                        xor_q <= xor_q ^ rx_data;
                        state <= DATA_LO;
                    end
                    DATA_LO: begin
                        // Address uses the pre-increment count; the count
                        // and the strobe become visible in the same cycle.
                        xor_q     <= xor_q ^ rx_data;
                        we_q      <= 1'b1;
                        mem_addr  <= PROG_START + word_cnt;
                        mem_wdata <= {hi_q, rx_data};
                        word_cnt  <= cnt_next;
                        state     <= (cnt_next == len_q) ? CHECK : DATA_HI;
                    end
                    CHECK: begin
                        if (rx_data == xor_q) begin
                            state   <= DONE;
                            cpu_rst <= 1'b0;
                            rdy_q   <= 1'b0;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end
                    end
                    ERROR: begin
                        if (rx_data == MAGIC) begin
                            state    <= LEN_HI;
                            load_err <= 1'b0;
                            word_cnt <= 16'h0000;
                            xor_q    <= 8'h00;
                        end
                    end
                    default: begin
                        // DONE: terminal until reset; never accepts anyway.
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames, expected RAM writes queued as
// {addr, data} and checked by an independent write monitor.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_rst;
    logic        load_err;
    logic [15:0] word_cnt;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_rst   (cpu_rst),
        .load_err  (load_err),
        .word_cnt  (word_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Present a byte and complete exactly one transfer. rx_valid stays high
    // afterwards so consecutive calls stream one byte per cycle.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte %h never accepted", b);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_bus();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic exp_write(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with nothing expected",
                         mem_addr, mem_wdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             mem_addr, mem_wdata, e[31:16], e[15:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rx_ready",  32'(rx_ready),  32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_rst",   32'(cpu_rst),   32'd1);
        chk("rst_load_err",  32'(load_err),  32'd0);
        chk("rst_word_cnt",  32'(word_cnt),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd1);

        // Good two-word frame
        exp_write(16'h000F, 16'h1234);
        exp_write(16'h0010, 16'hABCD);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        chk("good_cpu_rst_before_chk", 32'(cpu_rst), 32'd1);
        send_byte(8'h40);
        idle_bus();
        chk("good_cpu_rst",  32'(cpu_rst),  32'd0);
        chk("good_rx_ready", 32'(rx_ready), 32'd0);
        chk("good_word_cnt", 32'(word_cnt), 32'd2);
        chk("good_load_err", 32'(load_err), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_terminal_cpu_rst", 32'(cpu_rst), 32'd0);
        drain("good_queue_empty");

        // Bad checksum, then recovery from ERROR
        apply_reset();
        exp_write(16'h000F, 16'h1234);
        exp_write(16'h0010, 16'hABCD);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h41);
        idle_bus();
        chk("badchk_load_err", 32'(load_err), 32'd1);
        chk("badchk_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("badchk_rx_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h77);
        idle_bus();
        chk("err_discard_load_err", 32'(load_err), 32'd1);
        exp_write(16'h000F, 16'h1234);
        exp_write(16'h0010, 16'hABCD);
        send_byte(8'hA5);
        idle_bus();
        chk("err_magic_clears_load_err", 32'(load_err), 32'd0);
        chk("err_magic_clears_word_cnt", 32'(word_cnt), 32'd0);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h40);
        idle_bus();
        chk("recover_cpu_rst",  32'(cpu_rst),  32'd0);
        chk("recover_word_cnt", 32'(word_cnt), 32'd2);
        drain("recover_queue_empty");

        // Leading junk, zero-length frame
        apply_reset();
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle_bus();
        chk("zero_len_cpu_rst",  32'(cpu_rst),  32'd0);
        chk("zero_len_word_cnt", 32'(word_cnt), 32'd0);
        chk("zero_len_load_err", 32'(load_err), 32'd0);
        drain("zero_len_queue_empty");

        // LEN = MAX_WORDS + 1 (1025 = 16'h0401)
        apply_reset();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        idle_bus();
        chk("overlen_load_err", 32'(load_err), 32'd1);
        chk("overlen_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("overlen_word_cnt", 32'(word_cnt), 32'd0);
        // LEN = MAX_WORDS is accepted: no error after LEN_LO
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
        idle_bus();
        chk("maxlen_load_err", 32'(load_err), 32'd0);
        drain("overlen_queue_empty");

        // Reset mid-frame after the high byte of word 1
        apply_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("midrst_rx_ready", 32'(rx_ready),  32'd0);
        chk("midrst_mem_we",   32'(mem_we),    32'd0);
        chk("midrst_addr",     32'(mem_addr),  32'd0);
        chk("midrst_wdata",    32'(mem_wdata), 32'd0);
        chk("midrst_cpu_rst",  32'(cpu_rst),   32'd1);
        chk("midrst_word_cnt", 32'(word_cnt),  32'd0);
        rst = 1'b1;
        exp_write(16'h000F, 16'hBEEF);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h51);
        idle_bus();
        chk("midrst_reload_cpu_rst", 32'(cpu_rst), 32'd0);
        drain("midrst_queue_empty");

        // Streaming: rx_valid held high, one byte per cycle
        apply_reset();
        exp_write(16'h000F, 16'h1122);
        exp_write(16'h0010, 16'h3344);
        exp_write(16'h0011, 16'h5566);
        send_byte(8'hA5);
        c0 = cyc;
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h77);
        chk("stream_cycles", 32'(cyc - c0), 32'd9);
        idle_bus();
        chk("stream_word_cnt", 32'(word_cnt), 32'd3);
        chk("stream_cpu_rst",  32'(cpu_rst),  32'd0);
        drain("stream_queue_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
